// File: rtl/vga_frame_blitter_if.sv
// Bus bundle for the frame blitter: CSR responder port, image-fetch initiator and VGA plot initiator.
// master = blitter side, slave = system side (CPU, memory, VGA responder).
interface vga_frame_blitter_if;
    logic [3:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        write;
    logic [31:0] writedata;

    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;

    logic [31:0] vga_address;
    logic        vga_write;
    logic        vga_waitrequest;
    logic [31:0] vga_writedata;

    modport master (
        input  address, read, write, writedata,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid,
        input  vga_waitrequest,
        output readdata,
        output mem_address, mem_read,
        output vga_address, vga_write, vga_writedata
    );

    modport slave (
        output address, read, write, writedata,
        output mem_waitrequest, mem_readdata, mem_readdatavalid,
        output vga_waitrequest,
        input  readdata,
        input  mem_address, mem_read,
        input  vga_address, vga_write, vga_writedata
    );
endinterface

// File: rtl/vga_frame_blitter.sv
// Fetches an 8-bit greyscale image word by word and issues one VGA plot write per pixel,
// in raster order. Programmed and started through a small CSR port; status is polled.
module vga_frame_blitter #(
    parameter int unsigned IMG_W = 160,
    parameter int unsigned IMG_H = 120
) (
    input  logic                 clk,
    input  logic                 reset_n,
    vga_frame_blitter_if.master  bus_io
);

    localparam logic [7:0] XMax = 8'(IMG_W - 1);
    localparam logic [6:0] YMax = 7'(IMG_H - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWaitd, StPlot, StFinish} state_e;

    state_e      state_q, state_d;
    logic [31:0] img_base_q, img_base_d;
    logic [31:0] vga_base_q, vga_base_d;
    logic [31:0] img_lat_q, img_lat_d;
    logic [31:0] vga_lat_q, vga_lat_d;
    logic [31:0] pix_q, pix_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [13:0] w_q, w_d;
    logic [1:0]  k_q, k_d;

    logic        start;
    logic        last_pix;
    logic [7:0]  pix_byte;

    // Base registers are word aligned, so the low write-data bits are dropped.
    logic unused_wdata;
    assign unused_wdata = ^bus_io.writedata[1:0];

    assign start    = bus_io.write && (bus_io.address == 4'd2) && !busy_q;
    assign last_pix = (x_q == XMax) && (y_q == YMax);
    assign pix_byte = pix_q[{k_q, 3'b000} +: 8];

    assign bus_io.readdata = (bus_io.read && (bus_io.address == 4'd0)) ?
                             {30'b0, done_q, busy_q} : 32'b0;

    always_comb begin
        state_d    = state_q;
        img_base_d = img_base_q;
        vga_base_d = vga_base_q;
        img_lat_d  = img_lat_q;
        vga_lat_d  = vga_lat_q;
        pix_d      = pix_q;
        busy_d     = busy_q;
        done_d     = done_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        k_d        = k_q;

        bus_io.mem_read      = 1'b0;
        bus_io.mem_address   = 32'b0;
        bus_io.vga_write     = 1'b0;
        bus_io.vga_address   = 32'b0;
        bus_io.vga_writedata = 32'b0;

        if (bus_io.write && (bus_io.address == 4'd0)) begin
            img_base_d = {bus_io.writedata[31:2], 2'b00};
        end
        if (bus_io.write && (bus_io.address == 4'd1)) begin
            vga_base_d = {bus_io.writedata[31:2], 2'b00};
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d       = 8'd0;
                    y_d       = 7'd0;
                    w_d       = 14'd0;
                    k_d       = 2'd0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    img_lat_d = img_base_q;
                    vga_lat_d = vga_base_q;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                bus_io.mem_read    = 1'b1;
                bus_io.mem_address = img_lat_q + {16'b0, w_q, 2'b00};
                if (!bus_io.mem_waitrequest) begin
                    state_d = StWaitd;
                end
            end
            StWaitd: begin
                if (bus_io.mem_readdatavalid) begin
                    pix_d   = bus_io.mem_readdata;
                    k_d     = 2'd0;
                    state_d = StPlot;
                end
            end
            StPlot: begin
                bus_io.vga_write     = 1'b1;
                bus_io.vga_address   = vga_lat_q;
                bus_io.vga_writedata = {1'b0, y_q, x_q, 8'h00, pix_byte};
                if (!bus_io.vga_waitrequest) begin
                    if (x_q == XMax) begin
                        x_d = 8'd0;
                        y_d = y_q + 7'd1;
                    end else begin
                        x_d = x_q + 8'd1;
                    end
                    // Width is a multiple of 4, so the frame always ends on the last byte of a word.
                    if (k_q == 2'd3) begin
                        w_d     = w_q + 14'd1;
                        state_d = last_pix ? StFinish : StFetch;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            img_base_q <= 32'b0;
            vga_base_q <= 32'b0;
            img_lat_q  <= 32'b0;
            vga_lat_q  <= 32'b0;
            pix_q      <= 32'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            x_q        <= 8'd0;
            y_q        <= 7'd0;
            w_q        <= 14'd0;
            k_q        <= 2'd0;
        end else begin
            state_q    <= state_d;
            img_base_q <= img_base_d;
            vga_base_q <= vga_base_d;
            img_lat_q  <= img_lat_d;
            vga_lat_q  <= vga_lat_d;
            pix_q      <= pix_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            k_q        <= k_d;
        end
    end

endmodule

// File: tb/tb_vga_frame_blitter.sv
// Directed bench for vga_frame_blitter on an 8x2 image: memory/VGA models with optional random
// stalls and read latency, and a scoreboard of expected fetch addresses and plot writes.
module tb_vga_frame_blitter;

    localparam int unsigned W = 8;
    localparam int unsigned H = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_frame_blitter_if bus ();

    vga_frame_blitter #(.IMG_W(W), .IMG_H(H)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_io (bus.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int stab_err = 0;
    int ovl_err  = 0;
    bit rand_mode  = 1'b0;
    bit force_wait = 1'b0;

    logic [31:0] exp_fetch[$];
    logic [31:0] obs_fetch[$];
    logic [63:0] exp_wr[$];
    logic [63:0] obs_wr[$];

    // Memory content: every byte holds the low 8 bits of its own address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] b0, b1, b2, b3;
        b0 = a;
        b1 = a + 32'd1;
        b2 = a + 32'd2;
        b3 = a + 32'd3;
        return {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    // Memory and VGA responder models: sample at negedge, drive just after posedge.
    bit          pending = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] pend_addr = 32'b0;
    bit          acc_f, rdv_now;
    bit          pv_stall = 1'b0, pm_stall = 1'b0;
    logic [63:0] pv = 64'b0;
    logic [31:0] pm = 32'b0;

    always begin
        @(negedge clk);
        acc_f   = 1'b0;
        rdv_now = bus.mem_readdatavalid;
        if (!reset_n) begin
            pending  = 1'b0;
            pv_stall = 1'b0;
            pm_stall = 1'b0;
            rdv_now  = 1'b0;
        end else begin
            if (pv_stall && !(bus.vga_write && ({bus.vga_address, bus.vga_writedata} === pv)))
                stab_err++;
            if (pm_stall && !(bus.mem_read && (bus.mem_address === pm)))
                stab_err++;
            if (bus.vga_write && (pending || bus.mem_read))
                ovl_err++;
            if (bus.vga_write && !bus.vga_waitrequest)
                obs_wr.push_back({bus.vga_address, bus.vga_writedata});
            if (bus.mem_read && !bus.mem_waitrequest) begin
                obs_fetch.push_back(bus.mem_address);
                acc_f     = 1'b1;
                pend_addr = bus.mem_address;
            end
            pv_stall = bus.vga_write && bus.vga_waitrequest;
            pv       = {bus.vga_address, bus.vga_writedata};
            pm_stall = bus.mem_read && bus.mem_waitrequest;
            pm       = bus.mem_address;
        end
        @(posedge clk);
        #1;
        bus.mem_readdatavalid = 1'b0;
        bus.mem_readdata      = 32'b0;
        if (rdv_now) pending = 1'b0;
        if (acc_f) begin
            pending = 1'b1;
            lat_cnt = rand_mode ? int'($urandom_range(7, 1)) : 1;
        end
        if (pending && !rdv_now) begin
            if (lat_cnt <= 1) begin
                bus.mem_readdatavalid = 1'b1;
                bus.mem_readdata      = mem_word(pend_addr);
            end else begin
                lat_cnt--;
            end
        end
        bus.mem_waitrequest = rand_mode ? 1'($urandom_range(1, 0)) : 1'b0;
        bus.vga_waitrequest = force_wait ? 1'b1 :
                              (rand_mode ? 1'($urandom_range(1, 0)) : 1'b0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.address   = a;
        bus.write     = 1'b1;
        bus.writedata = d;
        @(posedge clk);
        #1;
        bus.write     = 1'b0;
        bus.address   = 4'd0;
        bus.writedata = 32'b0;
    endtask

    task automatic csr_rd(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk);
        #1;
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clk);
        d = bus.readdata;
        bus.read    = 1'b0;
        bus.address = 4'd0;
    endtask

    task automatic push_frame(input logic [31:0] ib, input logic [31:0] vb);
        logic [7:0]  xx;
        logic [6:0]  yy;
        logic [31:0] a;
        for (int w = 0; w < int'(W * H / 4); w++) exp_fetch.push_back(ib + 32'(4 * w));
        for (int i = 0; i < int'(W * H); i++) begin
            xx = 8'(i % int'(W));
            yy = 7'(i / int'(W));
            a  = ib + 32'(i);
            exp_wr.push_back({vb, 1'b0, yy, xx, 8'h00, a[7:0]});
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            csr_rd(4'd0, s);
            if (s[1]) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_nwrites"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        chk({tag, "_nfetches"}, 64'(obs_fetch.size()), 64'(exp_fetch.size()));
        while (exp_wr.size() > 0 && obs_wr.size() > 0)
            chk({tag, "_write"}, obs_wr.pop_front(), exp_wr.pop_front());
        while (exp_fetch.size() > 0 && obs_fetch.size() > 0)
            chk({tag, "_fetch"}, 64'(obs_fetch.pop_front()), 64'(exp_fetch.pop_front()));
        exp_wr.delete();
        obs_wr.delete();
        exp_fetch.delete();
        obs_fetch.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [63:0] v;
        bus.address   = 4'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'b0;

        // T1: reset with random inputs
        reset_n   = 1'b0;
        rand_mode = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            bus.address   = 4'($urandom);
            bus.read      = 1'($urandom);
            bus.write     = 1'($urandom);
            bus.writedata = $urandom;
        end
        @(negedge clk);
        chk("t1_mem_read", 64'(bus.mem_read), 64'd0);
        chk("t1_vga_write", 64'(bus.vga_write), 64'd0);
        chk("t1_mem_address", 64'(bus.mem_address), 64'd0);
        chk("t1_vga_address", 64'(bus.vga_address), 64'd0);
        chk("t1_vga_writedata", 64'(bus.vga_writedata), 64'd0);
        bus.write = 1'b0;
        bus.writedata = 32'b0;
        csr_rd(4'd0, s);
        chk("t1_status", 64'(s), 64'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        rand_mode = 1'b0;
        repeat (2) @(posedge clk);

        // T2: zero-wait frame
        csr_wr(4'd0, 32'h0000_0103);
        csr_wr(4'd1, 32'h0000_2000);
        push_frame(32'h100, 32'h2000);
        csr_wr(4'd2, 32'h1);
        wait_done("t2");
        v = (obs_wr.size() > 0) ? obs_wr[0] : '1;
        chk("t2_first_write", v, 64'h0000_2000_0000_0000);
        v = (obs_wr.size() > 4) ? obs_wr[4] : '1;
        chk("t2_fifth_write", v, 64'h0000_2000_0004_0004);
        v = (obs_wr.size() > 8) ? obs_wr[8] : '1;
        chk("t2_ninth_write", v, 64'h0000_2000_0100_0008);
        v = (obs_fetch.size() > 3) ? 64'(obs_fetch[3]) : '1;
        chk("t2_last_fetch", v, 64'h10C);
        check_frame("t2");
        csr_rd(4'd0, s);
        chk("t2_status", 64'(s), 64'h2);
        csr_rd(4'd1, s);
        chk("t2_read_off1", 64'(s), 64'd0);
        csr_rd(4'd2, s);
        chk("t2_read_off2", 64'(s), 64'd0);

        // T3: random stalls and read latency
        rand_mode = 1'b1;
        push_frame(32'h100, 32'h2000);
        csr_wr(4'd2, 32'h0);
        wait_done("t3");
        rand_mode = 1'b0;
        check_frame("t3");
        chk("t3_stable_during_stall", 64'(stab_err), 64'd0);
        chk("t3_no_write_while_fetch", 64'(ovl_err), 64'd0);

        // T4: START and IMG_BASE rewritten mid-frame
        push_frame(32'h100, 32'h2000);
        csr_wr(4'd2, 32'h0);
        for (int i = 0; i < 200 && obs_wr.size() < 3; i++) @(negedge clk);
        csr_wr(4'd2, 32'h0);
        csr_wr(4'd2, 32'h0);
        csr_wr(4'd0, 32'h0000_0140);
        wait_done("t4a");
        check_frame("t4a");
        push_frame(32'h140, 32'h2000);
        csr_wr(4'd2, 32'h0);
        csr_rd(4'd0, s);
        chk("t4_start_clears_done", 64'(s), 64'h1);
        wait_done("t4b");
        check_frame("t4b");

        // T5: reset while stalled in the third plot of a word
        csr_wr(4'd2, 32'h0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (obs_wr.size() >= 2) break;
        end
        force_wait = 1'b1;
        chk("t5_two_accepted", 64'(obs_wr.size()), 64'd2);
        @(negedge clk);
        #2;
        chk("t5_stalled_write", 64'(bus.vga_write), 64'd1);
        chk("t5_stalled_data", 64'(bus.vga_writedata), 64'h0002_0042);
        reset_n = 1'b0;
        @(negedge clk);
        #2;
        chk("t5_reset_vga_write", 64'(bus.vga_write), 64'd0);
        chk("t5_reset_mem_read", 64'(bus.mem_read), 64'd0);
        chk("t5_reset_vga_data", 64'(bus.vga_writedata), 64'd0);
        reset_n    = 1'b1;
        force_wait = 1'b0;
        csr_rd(4'd0, s);
        chk("t5_status_after_reset", 64'(s), 64'd0);
        obs_wr.delete();
        obs_fetch.delete();
        exp_wr.delete();
        exp_fetch.delete();
        push_frame(32'h0, 32'h0);
        csr_wr(4'd2, 32'h0);
        wait_done("t5");
        check_frame("t5");
        csr_rd(4'd0, s);
        chk("t5_status", 64'(s), 64'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
